// File: rtl/mult_share_arb_pkg.sv
// Shared types and helpers for the mult_share_arb multiplier-sharing arbiter.
package mult_share_arb_pkg;

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        WAIT,
        RESP
    } state_t;

    localparam int ERR_CNT_W = 4;

    function automatic int idx_w(input int n);
        return $clog2(n);
    endfunction

endpackage

// File: rtl/mult_share_arb_rr_pick.sv
// Round-robin pick: first valid requester at or after ptr, wrapping modulo N_REQ.
module rr_pick
    import mult_share_arb_pkg::*;
#(
    parameter int N_REQ = 4
) (
    input  logic [N_REQ-1:0]        valid,
    input  logic [idx_w(N_REQ)-1:0] ptr,
    output logic [N_REQ-1:0]        grant,
    output logic [idx_w(N_REQ)-1:0] grant_idx,
    output logic                    any_valid
);

    localparam int IW = idx_w(N_REQ);
    localparam logic [IW:0] NR_W = (IW+1)'(N_REQ);
    localparam logic [N_REQ-1:0] ONE = N_REQ'(1);

    logic [2*N_REQ-1:0] dbl;
    logic [N_REQ-1:0]   rot;
    logic [IW-1:0]      off;
    logic [IW:0]        sum;
    logic               found;

    always_comb begin
        // Rotate so ptr sits at bit 0, take the lowest set bit, then rotate the offset back.
        dbl   = {valid, valid} >> ptr;
        rot   = dbl[N_REQ-1:0];
        off   = '0;
        found = 1'b0;
        for (int unsigned i = 0; i < N_REQ; i++) begin
            if (!found && rot[i]) begin
                found = 1'b1;
                off   = IW'(i);
            end
        end
        sum = {1'b0, ptr} + {1'b0, off};
        if (sum >= NR_W) begin
            sum = sum - NR_W;
        end
        any_valid = |valid;
        grant_idx = sum[IW-1:0];
        grant     = any_valid ? (ONE << grant_idx) : '0;
    end

endmodule

// File: rtl/mult_share_arb.sv
// Round-robin sharing of one multi-cycle multiplier core among N_REQ requesters.
// Optional WAIT watchdog enabled by defining MULT_SHARE_ARB_TIMEOUT_EN.
module mult_share_arb
    import mult_share_arb_pkg::*;
#(
    parameter int W       = 32,
    parameter int N_REQ   = 4,
    parameter int TIMEOUT = 255
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [N_REQ-1:0]       req_valid,
    output logic [N_REQ-1:0]       req_ready,
    input  logic [N_REQ*W-1:0]     req_a,
    input  logic [N_REQ*W-1:0]     req_b,
    output logic [N_REQ-1:0]       resp_valid,
    input  logic [N_REQ-1:0]       resp_ready,
    output logic [2*W-1:0]         resp_p,
    output logic                   resp_err,
    output logic                   busy,
    output logic                   mul_start,
    output logic [W-1:0]           mul_a,
    output logic [W-1:0]           mul_b,
    input  logic                   mul_done,
    input  logic [2*W-1:0]         mul_p,
    output logic [ERR_CNT_W-1:0]   err_cnt
);

    localparam int IW = idx_w(N_REQ);

    if (N_REQ < 2 || N_REQ > 16 || TIMEOUT < 1) begin : g_bad_param
        $error("mult_share_arb: parameter out of range");
    end

    state_t           state;
    logic [IW-1:0]    rr_ptr;
    logic [IW-1:0]    grant_idx_q;
    logic [N_REQ-1:0] grant_q;
    logic [IW-1:0]    pick_idx;
    logic [N_REQ-1:0] pick_grant;
    logic             any_valid;
    logic [IW-1:0]    next_ptr;

    rr_pick #(
        .N_REQ(N_REQ)
    ) u_pick (
        .valid    (req_valid),
        .ptr      (rr_ptr),
        .grant    (pick_grant),
        .grant_idx(pick_idx),
        .any_valid(any_valid)
    );

    assign req_ready = (state == IDLE && !rst) ? pick_grant : '0;
    assign busy      = (state != IDLE);
    assign next_ptr  = (grant_idx_q == IW'(N_REQ-1)) ? '0 : grant_idx_q + 1'b1;

`ifdef MULT_SHARE_ARB_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT + 1);
    logic [TW-1:0] wd_cnt;
    logic          wd_expired;
    assign wd_expired = (wd_cnt == TW'(TIMEOUT - 1));
`else
    assign resp_err = 1'b0;
    assign err_cnt  = '0;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            rr_ptr      <= '0;
            grant_idx_q <= '0;
            grant_q     <= '0;
            mul_start   <= 1'b0;
            mul_a       <= '0;
            mul_b       <= '0;
            resp_valid  <= '0;
            resp_p      <= '0;
`ifdef MULT_SHARE_ARB_TIMEOUT_EN
            wd_cnt      <= '0;
            resp_err    <= 1'b0;
            err_cnt     <= '0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (any_valid) begin
                        grant_idx_q <= pick_idx;
                        grant_q     <= pick_grant;
                        mul_a       <= req_a[pick_idx*W +: W];
                        mul_b       <= req_b[pick_idx*W +: W];
                        mul_start   <= 1'b1;
                        state       <= ISSUE;
                    end
                end
                ISSUE: begin
                    mul_start <= 1'b0;
                    state     <= WAIT;
`ifdef MULT_SHARE_ARB_TIMEOUT_EN
                    wd_cnt    <= '0;
`endif
                end
                WAIT: begin
                    // A done in the expiry cycle takes priority over the abort.
                    if (mul_done) begin
                        resp_p     <= mul_p;
                        resp_valid <= grant_q;
                        state      <= RESP;
`ifdef MULT_SHARE_ARB_TIMEOUT_EN
                        resp_err   <= 1'b0;
                    end else if (wd_expired) begin
                        resp_p     <= '0;
                        resp_err   <= 1'b1;
                        resp_valid <= grant_q;
                        state      <= RESP;
                        if (err_cnt != '1) begin
                            err_cnt <= err_cnt + 1'b1;
                        end
                    end else begin
                        wd_cnt <= wd_cnt + 1'b1;
`endif
                    end
                end
                RESP: begin
                    if (resp_ready[grant_idx_q]) begin
                        resp_valid <= '0;
                        rr_ptr     <= next_ptr;
                        state      <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mult_share_arb.sv
// Scoreboard bench for mult_share_arb with a behavioural multi-cycle core model.
module tb_mult_share_arb;

    localparam int W   = 32;
    localparam int NR  = 4;
    localparam int TMO = 8;

    typedef struct {
        int             idx;
        logic [W-1:0]   a;
        logic [W-1:0]   b;
        logic [2*W-1:0] p;
        logic           err;
        int             rcyc;
    } op_t;

    logic              clk = 1'b0;
    logic              rst;
    logic [NR-1:0]     req_valid;
    logic [NR-1:0]     req_ready;
    logic [NR*W-1:0]   req_a;
    logic [NR*W-1:0]   req_b;
    logic [NR-1:0]     resp_valid;
    logic [NR-1:0]     resp_ready;
    logic [2*W-1:0]    resp_p;
    logic              resp_err;
    logic              busy;
    logic              mul_start;
    logic [W-1:0]      mul_a;
    logic [W-1:0]      mul_b;
    logic              mul_done;
    logic [2*W-1:0]    mul_p;
    logic [3:0]        err_cnt;

    op_t ops[$];
    op_t sb[$];
    int  acc_order[$];
    op_t mon_e;

    int  cyc = 0;
    int  lat = 3;
    int  n_checks = 0;
    int  n_err = 0;
    int  last_acc = -10;
    logic [W-1:0]   last_a = '0;
    logic [W-1:0]   last_b = '0;
    logic [2*W-1:0] held_p = '0;
    logic [NR-1:0]  prev_rv = '0;
    bit  stall = 0;
    bit  stray = 0;
    bit  stray_issue = 0;

    mult_share_arb #(
        .W      (W),
        .N_REQ  (NR),
        .TIMEOUT(TMO)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_a     (req_a),
        .req_b     (req_b),
        .resp_valid(resp_valid),
        .resp_ready(resp_ready),
        .resp_p    (resp_p),
        .resp_err  (resp_err),
        .busy      (busy),
        .mul_start (mul_start),
        .mul_a     (mul_a),
        .mul_b     (mul_b),
        .mul_done  (mul_done),
        .mul_p     (mul_p),
        .err_cnt   (err_cnt)
    );

    initial forever #5 clk = ~clk;

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, got, exp, cyc);
        end
    endtask

    function automatic op_t mk(input int idx, input logic [W-1:0] a, input logic [W-1:0] b,
                               input logic [2*W-1:0] p, input logic err);
        op_t o;
        o.idx = idx; o.a = a; o.b = b; o.p = p; o.err = err; o.rcyc = 0;
        return o;
    endfunction

    function automatic int find_next(input int i, input int from);
        for (int k = from; k < ops.size(); k++) begin
            if (ops[k].idx == i) return k;
        end
        return ops.size();
    endfunction

    task automatic present(input int i, input int k);
        if (k < ops.size()) begin
            req_valid[i]     = 1'b1;
            req_a[i*W +: W]  = ops[k].a;
            req_b[i*W +: W]  = ops[k].b;
        end else begin
            req_valid[i] = 1'b0;
        end
    endtask

    // Presents every op in ops (each requester in list order); call at a negedge.
    task automatic issue_all();
        int  nx[NR];
        int  remaining;
        int  guard;
        int  got;
        op_t e;
        remaining = ops.size();
        guard = 0;
        for (int i = 0; i < NR; i++) begin
            nx[i] = find_next(i, 0);
            present(i, nx[i]);
        end
        while (remaining > 0 && guard < 300) begin
            #1;
            got = -1;
            for (int i = 0; i < NR; i++) begin
                if (req_ready[i] && got < 0) got = i;
            end
            if (got >= 0) begin
                e = ops[nx[got]];
                e.rcyc = cyc + 2 + (stall ? TMO : lat);
                sb.push_back(e);
                acc_order.push_back(got);
                last_acc = cyc;
                last_a = e.a;
                last_b = e.b;
                remaining--;
                @(posedge clk);
                #1;
                nx[got] = find_next(got, nx[got] + 1);
                present(got, nx[got]);
            end
            @(negedge clk);
            guard++;
        end
        check("accept_all", 64'(remaining), 64'(0));
    endtask

    task automatic drain();
        int n;
        n = 0;
        while ((sb.size() != 0 || busy) && n < 200) begin
            @(negedge clk);
            n++;
        end
        check("drain_sb", 64'(sb.size()), 64'(0));
        check("drain_idle", 64'(busy), 64'(0));
    endtask

    // Core model: latency lat from the start cycle; mul_p carries junk unless mul_done.
    initial begin
        int cd;
        logic [2*W-1:0] prod;
        cd = 0;
        prod = '0;
        mul_done = 1'b0;
        mul_p = '0;
        forever begin
            @(negedge clk);
            #2;
            mul_done = 1'b0;
            mul_p = 64'hDEAD_BEEF_DEAD_BEEF;
            if (cd > 0) begin
                cd--;
                if (cd == 0 && !stall) begin
                    mul_done = 1'b1;
                    mul_p = prod;
                end
            end
            if (mul_start) begin
                prod = 64'(mul_a) * 64'(mul_b);
                cd = lat;
                if (stray_issue) begin
                    mul_done = 1'b1;
                    mul_p = 64'h1234;
                end
            end
            if (stray) begin
                mul_done = 1'b1;
                mul_p = 64'h5678;
            end
        end
    end

    // Monitor: pops the scoreboard on each new response and checks protocol invariants.
    initial forever begin
        @(negedge clk);
        if (!rst) begin
            if (req_ready != '0) check("ready_onehot", 64'($countones(req_ready)), 64'(1));
            if (busy) check("ready_while_busy", 64'(req_ready), 64'(0));
            if (mul_start) begin
                check("start_cycle", 64'(cyc), 64'(last_acc + 1));
                check("mul_a", 64'(mul_a), 64'(last_a));
                check("mul_b", 64'(mul_b), 64'(last_b));
            end
            if (resp_valid != '0 && prev_rv == '0) begin
                if (sb.size() == 0) begin
                    check("unexpected_resp", 64'(resp_valid), 64'(0));
                end else begin
                    mon_e = sb.pop_front();
                    check("resp_onehot", 64'(resp_valid), 64'(4'b0001 << mon_e.idx));
                    check("resp_p", resp_p, mon_e.p);
                    check("resp_err", 64'(resp_err), 64'(mon_e.err));
                    check("resp_cycle", 64'(cyc), 64'(mon_e.rcyc));
                    check("resp_busy", 64'(busy), 64'(1));
                end
                held_p = resp_p;
            end else if (resp_valid != '0) begin
                check("resp_p_stable", resp_p, held_p);
                check("resp_valid_stable", 64'(resp_valid), 64'(prev_rv));
            end
        end
        prev_rv = resp_valid;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, got running expected finished");
        n_err++;
        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $fatal(1, "time limit");
    end

    initial begin
        int exp_ord[5] = '{0, 1, 2, 3, 0};
        int n;
        rst = 1'b1;
        req_valid = '0;
        req_a = '0;
        req_b = '0;
        resp_ready = '1;

        // All four requesters valid from reset; req_ready must stay low during reset.
        ops.push_back(mk(0, 3, 5, 64'd15, 1'b0));
        ops.push_back(mk(1, 10, 11, 64'd110, 1'b0));
        ops.push_back(mk(2, 1000, 1000, 64'd1000000, 1'b0));
        ops.push_back(mk(3, 100, 200, 64'd20000, 1'b0));
        ops.push_back(mk(0, 12, 12, 64'd144, 1'b0));
        for (int i = 0; i < NR; i++) present(i, find_next(i, 0));
        repeat (3) @(negedge clk);
        check("rst_req_ready", 64'(req_ready), 64'(0));
        check("rst_resp_valid", 64'(resp_valid), 64'(0));
        check("rst_resp_p", resp_p, 64'(0));
        check("rst_busy", 64'(busy), 64'(0));
        check("rst_mul_start", 64'(mul_start), 64'(0));
        check("rst_mul_a", 64'(mul_a), 64'(0));
        check("rst_mul_b", 64'(mul_b), 64'(0));
        check("rst_resp_err", 64'(resp_err), 64'(0));
        check("rst_err_cnt", 64'(err_cnt), 64'(0));
        rst = 1'b0;
        acc_order.delete();
        issue_all();
        drain();
        check("order_len", 64'(acc_order.size()), 64'(5));
        for (int k = 0; k < 5; k++) begin
            check("grant_order", 64'((k < acc_order.size()) ? acc_order[k] : -1), 64'(exp_ord[k]));
        end

        // Single request, L=3: ready at T, start at T+1, response at T+5.
        lat = 3;
        ops.delete();
        ops.push_back(mk(2, 7, 6, 64'd42, 1'b0));
        issue_all();
        drain();

        // Back-pressure on requester 1 with another request pending.
        lat = 5;
        resp_ready = 4'b1101;
        ops.delete();
        ops.push_back(mk(1, 9, 9, 64'd81, 1'b0));
        issue_all();
        n = 0;
        while (!resp_valid[1] && n < 50) begin
            @(negedge clk);
            n++;
        end
        check("bp_resp_seen", 64'(resp_valid[1]), 64'(1));
        ops.delete();
        ops.push_back(mk(3, 2, 3, 64'd6, 1'b0));
        present(3, 0);
        repeat (10) begin
            @(negedge clk);
            check("bp_busy", 64'(busy), 64'(1));
        end
        resp_ready = '1;
        @(negedge clk);
        check("bp_idle", 64'(busy), 64'(0));
        issue_all();
        drain();

        // Stray done in IDLE, then in ISSUE with full-range operands and L=1.
        lat = 1;
        stray = 1;
        repeat (3) @(negedge clk);
        stray = 0;
        @(negedge clk);
        check("stray_idle_busy", 64'(busy), 64'(0));
        check("stray_idle_valid", 64'(resp_valid), 64'(0));
        stray_issue = 1;
        ops.delete();
        ops.push_back(mk(1, '1, '1, 64'hFFFF_FFFE_0000_0001, 1'b0));
        issue_all();
        drain();
        stray_issue = 0;

        // Reset while in WAIT, then a late done; next service starts from rr_ptr=0.
        lat = 3;
        stall = 1;
        ops.delete();
        ops.push_back(mk(3, 5, 5, 64'd25, 1'b0));
        issue_all();
        repeat (3) @(negedge clk);
        check("pre_rst_busy", 64'(busy), 64'(1));
        rst = 1'b1;
        repeat (2) @(negedge clk);
        sb.delete();
        rst = 1'b0;
        stall = 0;
        stray = 1;
        @(negedge clk);
        stray = 0;
        @(negedge clk);
        check("late_done_valid", 64'(resp_valid), 64'(0));
        check("late_done_p", resp_p, 64'(0));
        check("late_done_busy", 64'(busy), 64'(0));
        check("late_done_mul_a", 64'(mul_a), 64'(0));
        ops.delete();
        ops.push_back(mk(2, 4, 4, 64'd16, 1'b0));
        ops.push_back(mk(0, 6, 7, 64'd42, 1'b0));
        acc_order.delete();
        issue_all();
        drain();
        check("post_rst_first", 64'((acc_order.size() > 0) ? acc_order[0] : -1), 64'(0));
        check("post_rst_second", 64'((acc_order.size() > 1) ? acc_order[1] : -1), 64'(2));

`ifdef MULT_SHARE_ARB_TIMEOUT_EN
        // Stalled core: abort after TMO cycles in WAIT, err_cnt saturates at 15.
        stall = 1;
        for (int k = 1; k <= 16; k++) begin
            ops.delete();
            ops.push_back(mk(0, 3, 3, 64'd0, 1'b1));
            issue_all();
            drain();
            check("err_cnt", 64'(err_cnt), 64'((k > 15) ? 15 : k));
        end
        stall = 0;
        ops.delete();
        ops.push_back(mk(1, 3, 3, 64'd9, 1'b0));
        issue_all();
        drain();
        check("err_cnt_hold", 64'(err_cnt), 64'(15));
`endif

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
